// File: rtl/mac_tx_arb_pkg.sv
// Shared MAC TX definitions: arbiter FSM states, byte-count width helper
// and the default inter-packet gap reused by the TX-side blocks.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_t;

  localparam int IPG_CYC_DEF = 3;

  // Byte-count field must encode 0..DATA_W/8 inclusive.
  function automatic int len_w(input int data_w);
    return $clog2(data_w / 8 + 1);
  endfunction

endpackage

// File: rtl/mac_tx_arb_if.sv
// Requester-side and MAC-side stream signals of the TX arbiter, bundled
// so the arbiter (slave) and its environment (master) share one port.
interface mac_tx_arb_if #(
  parameter int REQ_N  = 2,
  parameter int DATA_W = 16,
  parameter int LEN_W  = mac_pkg::len_w(DATA_W)
);

  logic [REQ_N-1:0]        req_valid_i;
  logic [REQ_N-1:0]        req_start_i;
  logic [REQ_N-1:0]        req_term_i;
  logic [REQ_N*DATA_W-1:0] req_data_i;
  logic [REQ_N*LEN_W-1:0]  req_len_i;
  logic [REQ_N-1:0]        req_ready_o;
  logic                    mac_ready_i;
  logic                    mac_valid_o;
  logic                    mac_start_o;
  logic                    mac_term_o;
  logic [DATA_W-1:0]       mac_data_o;
  logic [LEN_W-1:0]        mac_len_o;
  logic [REQ_N-1:0]        grant_o;
  logic                    proto_err_o;

  modport slave (
    input  req_valid_i, req_start_i, req_term_i, req_data_i, req_len_i, mac_ready_i,
    output req_ready_o, mac_valid_o, mac_start_o, mac_term_o, mac_data_o, mac_len_o,
           grant_o, proto_err_o
  );

  modport master (
    output req_valid_i, req_start_i, req_term_i, req_data_i, req_len_i, mac_ready_i,
    input  req_ready_o, mac_valid_o, mac_start_o, mac_term_o, mac_data_o, mac_len_o,
           grant_o, proto_err_o
  );

endinterface

// File: rtl/mac_tx_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping modulo N. Returns a one-hot winner, its index and a hit flag.
module rr_pick #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int k;
    logic found;
    found = 1'b0;
    k     = 0;
    win_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        win_o[k] = 1'b1;
        idx_o    = PW'(k);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-granular round-robin arbiter sharing one MAC TX stream between
// REQ_N requesters, with a programmable idle gap after every frame.
module mac_tx_arb
  import mac_pkg::*;
#(
  parameter int REQ_N   = 2,
  parameter int DATA_W  = 16,
  parameter int IPG_CYC = IPG_CYC_DEF
) (
  input logic         clk,
  input logic         reset,
  mac_tx_arb_if.slave bus
);

  localparam int LEN_W = len_w(DATA_W);
  localparam int PW    = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W / 8);

  state_t           r_state, w_nextState;
  logic [REQ_N-1:0] r_grant, w_grantNext;
  logic [PW-1:0]    r_gidx, w_gidxNext;
  logic [PW-1:0]    r_rr, w_rrNext;
  logic [3:0]       r_ipg, w_ipgNext;
  logic             r_midFrame, w_midFrameNext;

  logic [REQ_N-1:0] w_win;
  logic [PW-1:0]    w_winIdx;
  logic             w_any;
  logic             w_ownValid, w_ownStart, w_ownTerm, w_accept;

  rr_pick #(.N(REQ_N)) u_pick (
    .req_i (bus.req_valid_i & bus.req_start_i),
    .ptr_i (r_rr),
    .win_o (w_win),
    .idx_o (w_winIdx),
    .any_o (w_any)
  );

  assign w_ownValid  = bus.req_valid_i[r_gidx];
  assign w_ownStart  = bus.req_start_i[r_gidx];
  assign w_ownTerm   = bus.req_term_i[r_gidx];
  assign w_accept    = (r_state == XFER) && w_ownValid && bus.mac_ready_i;
  assign bus.grant_o = r_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr       <= '0;
      r_ipg      <= '0;
      r_midFrame <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_grant    <= w_grantNext;
      r_gidx     <= w_gidxNext;
      r_rr       <= w_rrNext;
      r_ipg      <= w_ipgNext;
      r_midFrame <= w_midFrameNext;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_grantNext     = r_grant;
    w_gidxNext      = r_gidx;
    w_rrNext        = r_rr;
    w_ipgNext       = r_ipg;
    w_midFrameNext  = r_midFrame;
    bus.req_ready_o = '0;
    bus.mac_valid_o = 1'b0;
    bus.mac_start_o = 1'b0;
    bus.mac_term_o  = 1'b0;
    bus.mac_data_o  = '0;
    bus.mac_len_o   = '0;
    bus.proto_err_o = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nextState    = XFER;
          w_grantNext    = w_win;
          w_gidxNext     = w_winIdx;
          w_midFrameNext = 1'b0;
        end
      end

      XFER: begin
        bus.req_ready_o[r_gidx] = bus.mac_ready_i;
        bus.mac_valid_o = w_ownValid;
        bus.mac_start_o = w_ownStart && !r_midFrame;
        bus.mac_term_o  = w_ownTerm;
        bus.mac_data_o  = bus.req_data_i[int'(r_gidx)*DATA_W +: DATA_W];
        bus.mac_len_o   = w_ownTerm ? bus.req_len_i[int'(r_gidx)*LEN_W +: LEN_W] : FULL_LEN;
        // A second start inside a frame is forwarded as data but flagged.
        bus.proto_err_o = w_accept && w_ownStart && r_midFrame;
        if (w_accept) begin
          if (w_ownTerm) begin
            w_rrNext       = PW'((int'(r_gidx) + 1) % REQ_N);
            w_grantNext    = '0;
            w_midFrameNext = 1'b0;
            w_ipgNext      = '0;
            w_nextState    = (IPG_CYC == 0) ? IDLE : GAP;
          end else begin
            w_midFrameNext = 1'b1;
          end
        end
      end

      GAP: begin
        if (r_ipg == 4'(IPG_CYC - 1)) begin
          w_ipgNext   = '0;
          w_nextState = IDLE;
        end else begin
          w_ipgNext = r_ipg + 4'd1;
        end
      end

      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: doc/mac_tx_arb.md
Name: mac_tx_arb

Overview:
Frame-granular round-robin arbiter that shares one MAC TX datapath between N upper-layer requesters (e.g. IPv4, ARP, debug injector). It grants a requester only at a frame boundary and holds the grant until that frame's term beat is accepted. It enforces a programmable idle gap between frames and muxes the granted stream onto the MAC TX input.

Parameters:
REQ_N, 2, number of requesters (2..8)
DATA_W, 16, beat width in bits (16, 32 or 64)
LEN_W, $clog2(DATA_W/8+1), width of byte-count field (local, derived)
IPG_CYC, 3, idle cycles inserted after each frame's term beat (0..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid_i  in  REQ_N  per-requester beat valid
req_start_i  in  REQ_N  beat is first of frame
req_term_i  in  REQ_N  beat is last of frame
req_data_i  in  REQ_N*DATA_W  requester data, requester k at [k*DATA_W +: DATA_W]
req_len_i  in  REQ_N*LEN_W  valid bytes on term beat, requester k at [k*LEN_W +: LEN_W]
req_ready_o  out  REQ_N  beat accepted from requester k this cycle when valid&ready
mac_ready_i  in  1  MAC TX can accept a beat
mac_valid_o  out  1  beat valid to MAC TX
mac_start_o  out  1  first beat of frame
mac_term_o  out  1  last beat of frame
mac_data_o  out  DATA_W  muxed data
mac_len_o  out  LEN_W  muxed len; DATA_W/8 on non-term beats
grant_o  out  REQ_N  one-hot current owner, 0 when none
proto_err_o  out  1  one-cycle pulse on protocol violation by owner

Behaviour:
- Reset: state IDLE, rr pointer 0, IPG counter 0, grant_o 0, req_ready_o 0, mac_valid_o/start/term 0, proto_err_o 0. Reset mid-frame discards the frame silently; no term is emitted.
- Accept: a beat is accepted when mac_valid_o & mac_ready_i.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - Candidates are requesters with req_valid_i & req_start_i.
  - The winner is the first candidate at or after rr pointer, wrapping modulo REQ_N.
  - Grant is registered; the next state is XFER with grant_o one-hot on the winner.
  - No beat is accepted in IDLE, so minimum latency from start to mac_valid_o is 1 cycle.
  - A valid requester without start is ignored and never granted.
- XFER:
  - mac_valid_o = req_valid_i[g]; req_ready_o[g] = mac_ready_i; all other req_ready_o are 0.
  - Data, start, term and len are muxed combinationally from owner g.
  - mac_len_o = req_len_i[g] on term beats, else DATA_W/8.
  - If the owner drops valid mid-frame, mac_valid_o is 0 and the grant is held; there is no timeout.
  - On an accepted term beat: rr pointer becomes g+1 mod REQ_N, grant_o clears, and the next state is GAP (or IDLE if IPG_CYC==0).
  - A single-beat frame (start & term on the same beat) is legal.
- GAP: counts IPG_CYC cycles. mac_valid_o and req_ready_o are 0. Then the next state is IDLE.
- proto_err_o pulses when the owner presents valid & start on a non-first beat of the frame in XFER. That beat is still forwarded with mac_start_o forced to 0.
- Backpressure: while mac_ready_i=0 the owner must hold its beat; the arbiter never re-arbitrates mid-frame.
- Simultaneous request and reset: reset wins.
- Fairness: with all REQ_N requesters continuously requesting, grants rotate 0,1,...,REQ_N-1,0.

Decomposition:
- Shared package mac_pkg holds:
  - the FSM state typedef (IDLE, XFER, GAP);
  - the LEN_W derivation function;
  - IPG_CYC default constant, reused by mac_tx and pcs_tx.
- One natural sub-module: rr_pick (combinational).
  - Inputs: request vector, rr pointer.
  - Outputs: one-hot winner and its index.
  - It is reusable by later RX-queue schedulers.

Test Plan:
- REQ_N=2. Req0 sends a 3-beat frame 0x1111,0x2222,0x3333, term len=1, mac_ready_i=1. Expect grant_o=01 one cycle after start. Expect mac_start_o on 0x1111, mac_term_o with mac_len_o=1 on 0x3333, then 3 GAP cycles with mac_valid_o=0.
- Both requesters start in the same cycle with rr=0. Expect req0 served first, then req1 after the gap. A repeat of the contention expects req1 deferred by none, i.e. rotation continues 0,1,0,1.
- Owner frame of 4 beats with mac_ready_i low for 2 cycles on beat 2. Expect beat 2 held stable on mac_data_o. Expect req_ready_o[g]=0 during the stall. Expect no beat loss or duplication.
- Owner asserts start on beat 3 of 5. Expect a single proto_err_o pulse and mac_start_o=0 on that beat. The frame completes normally.
- reset asserted during beat 2 of a frame. Expect all outputs 0 the next cycle and grant_o=0. A new start from req1 is granted with rr=0 ordering.
- IPG_CYC=0, single-beat frames from req0 back-to-back. Expect one idle (IDLE arbitration) cycle between mac_valid_o beats.
